stopwatch_ctrl: RTL and testbench

Run-control sequencer for the stopwatch. Consumes the 100 Hz divided clock level from the divider (clk_100hz), turns it into single-cycle count enables in the clk domain, and runs an IDLE/RUN/PAUSE/LAP state machine from start/stop, lap and clear buttons. Owns the mm:ss.cc BCD time counter and the lap-freeze display register that feed the display scanner.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_ctrl_bcd_digit.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 156 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] DIGIT_LIM_DEC = 4'd9;
  localparam logic [3:0] DIGIT_LIM_SEX = 4'd5;

  localparam int OFF_M1 = 20;
  localparam int OFF_M0 = 16;
  localparam int OFF_S1 = 12;
  localparam int OFF_S0 = 8;
  localparam int OFF_C1 = 4;
  localparam int OFF_C0 = 0;

  // Two-digit BCD of a small integer, used for the minute terminal compare.
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One modulo-(LIMIT+1) BCD digit with synchronous clear and ripple carry out.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] LIMIT = DIGIT_LIM_DEC
) (
  input  logic       clk,
  input  logic       clkcnt_reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk or negedge clkcnt_reset) begin
    if (!clkcnt_reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      // Out-of-range values fold back to zero instead of counting on.
      q <= (q >= LIMIT) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = inc && (q == LIMIT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: input synchronizers, IDLE/RUN/PAUSE/LAP sequencer,
// mm:ss.cc BCD counter and lap-freeze display register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINUTES = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        clkcnt_reset,
  input  logic        clk_100hz,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp_bcd,
  output logic [23:0] live_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam logic [7:0] MAX_BCD = to_bcd8(MAX_MINUTES);

  logic [3:0]                   raw_in;
  logic [SYNC_STAGES-1:0][3:0]  sync_pipe;
  logic [3:0]                   level_p1;
  logic [3:0]                   edge_det;
  logic [SYNC_STAGES:0]         warm;
  logic                         btn_ok;
  logic                         tick, ev_ss, ev_lap, ev_clr;

  assign raw_in = {btn_clear, btn_lap, btn_start_stop, clk_100hz};

  // Synchronizer and edge-detect stage
  always_ff @(posedge clk or negedge clkcnt_reset) begin
    if (!clkcnt_reset) begin
      sync_pipe <= '0;
      level_p1  <= '0;
      warm      <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw_in};
      level_p1  <= sync_pipe[SYNC_STAGES-1];
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign edge_det = sync_pipe[SYNC_STAGES-1] & ~level_p1;
  // Button edges are masked until the chain has refilled, so a button held
  // through reset release never looks like a fresh press.
  assign btn_ok   = warm[SYNC_STAGES];
  assign tick     = edge_det[0];
  assign ev_ss    = edge_det[1] & btn_ok;
  assign ev_lap   = edge_det[2] & btn_ok;
  assign ev_clr   = edge_det[3] & btn_ok;

  sw_state_e cur_st, nxt_st;
  logic      lap_cap, zero_live;

  always_comb begin
    nxt_st    = cur_st;
    lap_cap   = 1'b0;
    zero_live = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        if (ev_ss) nxt_st = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss) begin
          nxt_st = ST_PAUSE;
        end else if (ev_lap) begin
          nxt_st  = ST_LAP;
          lap_cap = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_ss)       nxt_st = ST_PAUSE;
        else if (ev_lap) nxt_st = ST_RUN;
      end
      ST_PAUSE: begin
        if (ev_ss) begin
          nxt_st = ST_RUN;
        end else if (ev_clr) begin
          nxt_st    = ST_IDLE;
          zero_live = 1'b1;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  logic       cnt_en;
  logic [3:0] c0_q, c1_q, s0_q, s1_q, m0_q, m1_q;
  logic       c0_co, c1_co, s0_co, s1_co, m0_co, m1_co;
  logic       min_at_max, min_over, min_wrap, min_clr;

  assign cnt_en = tick && (cur_st == ST_RUN || cur_st == ST_LAP);

  bcd_digit #(.LIMIT(DIGIT_LIM_DEC)) u_c0 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(cnt_en), .clr(zero_live),
    .q(c0_q), .carry(c0_co));
  bcd_digit #(.LIMIT(DIGIT_LIM_DEC)) u_c1 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(c0_co), .clr(zero_live),
    .q(c1_q), .carry(c1_co));
  bcd_digit #(.LIMIT(DIGIT_LIM_DEC)) u_s0 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(c1_co), .clr(zero_live),
    .q(s0_q), .carry(s0_co));
  bcd_digit #(.LIMIT(DIGIT_LIM_SEX)) u_s1 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(s0_co), .clr(zero_live),
    .q(s1_q), .carry(s1_co));
  bcd_digit #(.LIMIT(DIGIT_LIM_DEC)) u_m0 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(s1_co), .clr(min_clr),
    .q(m0_q), .carry(m0_co));
  bcd_digit #(.LIMIT(DIGIT_LIM_DEC)) u_m1 (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .inc(m0_co), .clr(min_clr),
    .q(m1_q), .carry(m1_co));

  // Minutes wrap at MAX_MINUTES rather than 99; lower digits roll over on
  // their own since they all sit at their limits when this fires.
  assign min_at_max = ({m1_q, m0_q} == MAX_BCD);
  assign min_over   = ({m1_q, m0_q} > MAX_BCD);
  assign min_wrap   = s1_co && min_at_max;
  assign min_clr    = zero_live || min_wrap || m1_co || (cnt_en && min_over);

  always_comb begin
    live_bcd = '0;
    live_bcd[OFF_M1 +: 4] = m1_q;
    live_bcd[OFF_M0 +: 4] = m0_q;
    live_bcd[OFF_S1 +: 4] = s1_q;
    live_bcd[OFF_S0 +: 4] = s0_q;
    live_bcd[OFF_C1 +: 4] = c1_q;
    live_bcd[OFF_C0 +: 4] = c0_q;
  end

  logic [23:0] lap_q;

  // State, lap latch and display register stage
  always_ff @(posedge clk or negedge clkcnt_reset) begin
    if (!clkcnt_reset) begin
      cur_st   <= ST_IDLE;
      lap_q    <= '0;
      disp_bcd <= '0;
      overflow <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      if (lap_cap) lap_q <= live_bcd;
      disp_bcd <= (cur_st == ST_LAP) ? lap_q : live_bcd;
      overflow <= min_wrap;
    end
  end

  assign state      = cur_st;
  assign running    = (cur_st == ST_RUN) || (cur_st == ST_LAP);
  assign lap_active = (cur_st == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a centisecond-count reference model.
module tb_stopwatch_ctrl;

  localparam int MAXM  = 1;
  localparam int SYNC  = 2;
  localparam int TOTAL = (MAXM + 1) * 6000;

  logic        clk = 1'b0;
  logic        clkcnt_reset = 1'b1;
  logic        clk_100hz = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [23:0] disp_bcd, live_bcd;
  logic        running, lap_active, overflow;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_MINUTES(MAXM), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .clkcnt_reset(clkcnt_reset), .clk_100hz(clk_100hz),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .disp_bcd(disp_bcd), .live_bcd(live_bcd), .running(running),
    .lap_active(lap_active), .overflow(overflow), .state(state));

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: time kept as plain centiseconds, states by their codes.
  int m_cs = 0, m_lap = 0, m_disp = 0, m_st = 0, n_edges = 0;
  bit m_ov = 1'b0;
  bit [SYNC+1:0] h_t = '0, h_s = '0, h_l = '0, h_c = '0;
  int ncs, nlap, nst;
  bit tk, e_s, e_l, e_c, bok, inc, nov;

  initial forever begin
    @(posedge clk or negedge clkcnt_reset);
    if (!clkcnt_reset) begin
      m_cs = 0; m_lap = 0; m_disp = 0; m_st = 0; m_ov = 1'b0; n_edges = 0;
      h_t = '0; h_s = '0; h_l = '0; h_c = '0;
    end else begin
      n_edges++;
      h_t = {h_t[SYNC:0], clk_100hz};
      h_s = {h_s[SYNC:0], btn_start_stop};
      h_l = {h_l[SYNC:0], btn_lap};
      h_c = {h_c[SYNC:0], btn_clear};
      bok = (n_edges >= SYNC + 2);
      tk  = h_t[SYNC] && !h_t[SYNC+1];
      e_s = h_s[SYNC] && !h_s[SYNC+1] && bok;
      e_l = h_l[SYNC] && !h_l[SYNC+1] && bok;
      e_c = h_c[SYNC] && !h_c[SYNC+1] && bok;
      inc = tk && (m_st == 1 || m_st == 3);
      ncs = m_cs; nov = 1'b0; nlap = m_lap; nst = m_st;
      if (inc) begin
        if (m_cs == TOTAL - 1) begin ncs = 0; nov = 1'b1; end
        else ncs = m_cs + 1;
      end
      case (m_st)
        0: if (e_s) nst = 1;
        1: if (e_s) nst = 2; else if (e_l) begin nst = 3; nlap = m_cs; end
        3: if (e_s) nst = 2; else if (e_l) nst = 1;
        default: if (e_s) nst = 1; else if (e_c) begin nst = 0; ncs = 0; end
      endcase
      m_disp = (m_st == 3) ? m_lap : m_cs;
      m_cs = ncs; m_lap = nlap; m_st = nst; m_ov = nov;
    end
  end

  always @(negedge clk) begin
    chk("live", 32'(live_bcd), 32'(to_bcd(m_cs)));
    chk("disp", 32'(disp_bcd), 32'(to_bcd(m_disp)));
    chk("ctl", 32'({state, running, lap_active}),
        32'({2'(m_st), (m_st == 1 || m_st == 3), (m_st == 3)}));
    chk("ovf", 32'(overflow), 32'(m_ov));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      clk_100hz = 1'b1;
      cyc(fast ? 1 : $urandom_range(1, 3));
      clk_100hz = 1'b0;
      cyc(fast ? 1 : $urandom_range(1, 3));
    end
  endtask

  task automatic press(input bit s, input bit l, input bit c);
    btn_start_stop = s; btn_lap = l; btn_clear = c;
    cyc($urandom_range(1, 3));
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(6);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int ov_cnt;

  initial begin
    #1 clkcnt_reset = 1'b0;
    cyc(3);
    #2 clkcnt_reset = 1'b1;
    cyc(8);
    chk("rst_state", 32'(state), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    chk("start", 32'(state), 32'd1);

    clk_100hz = 1'b1;
    cyc(1);
    cyc(1);
    chk("lat_before", 32'(live_bcd), 32'h0);
    cyc(1);
    chk("lat_3clk", 32'(live_bcd), 32'h000001);
    clk_100hz = 1'b0;
    cyc(1);
    tick_n(1233, 1'b0);
    cyc(4);
    chk("pre_reset", 32'(live_bcd), 32'h001234);

    btn_start_stop = 1'b1;
    #2 clkcnt_reset = 1'b0;
    cyc(2);
    chk("rst_clear", 32'({live_bcd, state, overflow}), 32'h0);
    chk("rst_disp", 32'(disp_bcd), 32'h0);
    #2 clkcnt_reset = 1'b1;
    cyc(10);
    chk("held_btn", 32'(state), 32'd0);
    btn_start_stop = 1'b0;
    cyc(3);
    press(1'b1, 1'b0, 1'b0);
    chk("restart", 32'(state), 32'd1);

    tick_n(150, 1'b0);
    cyc(4);
    chk("live150", 32'(live_bcd), 32'h000150);
    chk("disp150", 32'(disp_bcd), 32'h000150);

    tick_n(350, 1'b0);
    cyc(4);
    chk("live500", 32'(live_bcd), 32'h000500);
    press(1'b0, 1'b1, 1'b0);
    tick_n(100, 1'b0);
    cyc(4);
    chk("lap_disp", 32'(disp_bcd), 32'h000500);
    chk("lap_live", 32'(live_bcd), 32'h000600);
    chk("lap_act", 32'(lap_active), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    chk("unlap_disp", 32'(disp_bcd), 32'h000600);
    chk("unlap_state", 32'(state), 32'd1);

    tick_n(TOTAL - 1 - 600, 1'b1);
    cyc(4);
    chk("preload", 32'(live_bcd), 32'h015999);
    ov_cnt = 0;
    clk_100hz = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (i == 0) clk_100hz = 1'b0;
      if (overflow) ov_cnt++;
    end
    chk("ovf_pulse", 32'(ov_cnt), 32'd1);
    chk("wrap_live", 32'(live_bcd), 32'h0);
    chk("wrap_state", 32'(state), 32'd1);

    press(1'b1, 1'b0, 1'b0);
    chk("pause", 32'(state), 32'd2);
    press(1'b0, 1'b1, 1'b1);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_live", 32'(live_bcd), 32'h0);
    press(1'b1, 1'b0, 1'b0);
    tick_n(37, 1'b0);
    cyc(4);
    press(1'b1, 1'b1, 1'b0);
    chk("sslap_state", 32'(state), 32'd2);
    chk("sslap_nolap", 32'(lap_active), 32'd0);
    chk("sslap_disp", 32'(disp_bcd), 32'h000037);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("clr_in_run", 32'({live_bcd, state}), 32'({24'h000037, 2'd1}));

    clk_100hz = 1'b1; btn_start_stop = 1'b1;
    cyc(1);
    clk_100hz = 1'b0; btn_start_stop = 1'b0;
    cyc(6);
    chk("coinc_live", 32'(live_bcd), 32'h000038);
    chk("coinc_state", 32'(state), 32'd2);
    tick_n(20, 1'b0);
    cyc(4);
    chk("paused_hold", 32'(live_bcd), 32'h000038);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      clk_100hz      = 1'($urandom_range(0, 1));
      btn_start_stop = ($urandom_range(0, 19) == 0);
      btn_lap        = ($urandom_range(0, 9) == 0);
      btn_clear      = ($urandom_range(0, 9) == 0);
    end
    clk_100hz = 1'b0; btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
